// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write FIFO between MEM stage and data memory; optional forwarding via SB_STORE_FWD_EN.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       proc2Dmem_command,
  input  logic [31:0]      proc2Dmem_addr,
  input  logic [31:0]      proc2mem_data,
  output logic [31:0]      mem2proc_data,
  output logic             sb_stall,
  output logic [31:0]      mem_rd_addr,
  input  logic [31:0]      mem_rd_data,
  output logic             mem_wr_valid,
  input  logic             mem_wr_ready,
  output logic [31:0]      mem_wr_addr,
  output logic [31:0]      mem_wr_data,
  output logic [CNT_W-1:0] sb_count,
  output logic             sb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] BUS_LOAD = 2'h1, BUS_STORE = 2'h2;
  logic [29:0] sb_addr [DEPTH];
  logic [31:0] sb_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic is_load, is_store, drain, accept, hit;
  logic [31:0] fwd_data;
  assign is_load = proc2Dmem_command == BUS_LOAD;
  assign is_store = proc2Dmem_command == BUS_STORE;
  assign sb_count = count;
  assign sb_empty = count == '0;
  assign mem_rd_addr = proc2Dmem_addr;
  assign mem_wr_valid = !sb_empty;
  assign mem_wr_addr = mem_wr_valid ? {sb_addr[head], 2'b00} : '0;
  assign mem_wr_data = mem_wr_valid ? sb_data[head] : '0;
  assign drain = mem_wr_valid & mem_wr_ready;
  assign accept = is_store & ((count < CNT_W'(DEPTH)) | drain);
  // Scan oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (sb_addr[head + PW'(i)] == proc2Dmem_addr[31:2])) begin
        hit = 1'b1;
        fwd_data = sb_data[head + PW'(i)];
      end
    end
  end
`ifdef SB_STORE_FWD_EN
  assign mem2proc_data = !is_load ? '0 : hit ? fwd_data : mem_rd_data;
  assign sb_stall = is_store & !accept;
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_data;
  assign mem2proc_data = is_load ? mem_rd_data : '0;
  assign sb_stall = (is_store & !accept) | (is_load & hit);
`endif
  always_ff @(posedge clk) begin
    if (accept) begin
      sb_addr[tail] <= proc2Dmem_addr[31:2];
      sb_data[tail] <= proc2mem_data;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= drain ? head + 1'b1 : head;
      tail <= accept ? tail + 1'b1 : tail;
      count <= count + CNT_W'(accept) - CNT_W'(drain);
    end
  end
endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write store buffer between the processor's MEM-stage data bus and a backing data memory with a single-cycle combinational read port and a valid/ready write port. Stores retire into a DEPTH-entry FIFO in one cycle and drain to memory in order. Loads are serviced in the same cycle, with youngest-match store-to-load forwarding from the buffer. `sb_stall` tells the pipeline when a store cannot be absorbed.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of `sb_count`.

- clk  in  1  system clock; rising edge.
- rst  in  1  reset, asynchronous, active-high.
- proc2Dmem_command  in  2  `BUS_NONE` / `BUS_LOAD` / `BUS_STORE` (sys_defs encodings).
- proc2Dmem_addr  in  32  byte address; word-granular, bits [1:0] ignored.
- proc2mem_data  in  32  store data.
- mem2proc_data  out  32  load data to MEM stage.
- sb_stall  out  1  request cannot be accepted this cycle; pipeline holds it.
- mem_rd_addr  out  32  backing-memory read address.
- mem_rd_data  in  32  backing-memory read data, combinational.
- mem_wr_valid  out  1  head entry valid for write.
- mem_wr_ready  in  1  memory accepts write at this edge.
- mem_wr_addr  out  32  head entry address.
- mem_wr_data  out  32  head entry data.
- sb_count  out  CNT_W  occupied entries.
- sb_empty  out  1  `sb_count == 0`.

## Operation
- Storage: DEPTH entries of {addr[31:2], data[31:0]}, plus head pointer, tail pointer and count. Pointers are log2(DEPTH) bits and wrap naturally.
- drain = `mem_wr_valid & mem_wr_ready`. On drain, the head entry pops at the edge.
- Store (`BUS_STORE`):
  - Accepted when `count < DEPTH` or drain is true this cycle. On acceptance, the entry is written at the tail and the tail advances.
  - Otherwise `sb_stall=1` and nothing is written.
- Count update: +1 on accept only, −1 on drain only, unchanged when both or neither occur.
- Load (`BUS_LOAD`):
  - `mem_rd_addr = proc2Dmem_addr` at all times.
  - hit = any occupied entry with addr[31:2] equal to the load's addr[31:2]. This includes the entry draining this cycle.
  - On hit, `mem2proc_data` = data of the youngest matching entry (closest to the tail). On miss, `mem2proc_data = mem_rd_data`.
- `BUS_NONE`: `mem2proc_data = 0`, `sb_stall = 0`.
- Write port:
  - `mem_wr_valid = !sb_empty`.
  - `mem_wr_addr = {head.addr, 2'b00}` and `mem_wr_data = head.data` when valid, otherwise 0.
  - Entries drain strictly in program order, one per cycle at most.
- Duplicate addresses are not coalesced; each store occupies its own entry.

## Timing
- Reset: count=0, head=tail=0, `sb_empty=1`, `mem_wr_valid=0`, `mem_wr_addr=0`, `mem_wr_data=0`, `sb_stall=0`. Asserting reset mid-drain discards all entries and causes no writes.
- Load latency: 0 cycles (combinational). Store acceptance: 1 edge.
- A store accepted at edge N is forwardable to loads from cycle N+1 and presented on the write port from cycle N+1 at the earliest, i.e. when the buffer was empty.
- A store arriving while full, with a drain in the same cycle: accepted, no stall, count stays at DEPTH.
- `mem_wr_ready` held low indefinitely: the buffer fills, then every store stalls; loads continue unaffected.
- The write port must not change `mem_wr_addr`/`mem_wr_data` while `mem_wr_valid=1` and `mem_wr_ready=0`.

## Configuration
- `SB_STORE_FWD_EN` defined: loads that hit are forwarded as described, and loads never stall.
- `SB_STORE_FWD_EN` undefined: the forwarding mux is removed. A load that hits asserts `sb_stall=1` and is held until no matching entry remains, then returns `mem_rd_data`.
  - In this mode, a load hitting only the entry draining this cycle still stalls that cycle.

## Test plan
- Reset, then `BUS_NONE` with `mem_wr_ready=1` → `sb_empty=1`, `mem_wr_valid=0`, `mem2proc_data=0`, `sb_stall=0`.
- Store 0x100←0xAAAA0001 with `mem_wr_ready=0`, then load 0x100 → `mem2proc_data=0xAAAA0001` (FWD_EN) or `sb_stall=1` (no FWD_EN); `mem_wr_addr=0x100`.
- Stores 0x200←1 then 0x200←2, then load 0x202 → data 2 (youngest match, bits [1:0] ignored).
- `mem_wr_ready=0`, issue 5 stores with DEPTH=4 → the first four are accepted, `sb_count=4`, the fifth has `sb_stall=1`. Raise ready → the fifth is accepted that cycle and count stays at 4.
- Stores to 0x10, 0x14, 0x18 with ready toggling 1,0,1,1 → writes appear in order 0x10, 0x14, 0x18 with data stable while ready is low. Assert rst while two entries remain → `mem_wr_valid=0` immediately, and no further writes occur.
